// File: rtl/debug_uart_tx.sv
// debug_uart_tx: snapshots seven 8-bit debug ports and sends them as one 8N1 UART burst.
// Optional checksum byte is enabled by defining DEBUG_TX_CHECKSUM_EN.
module debug_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       trigger,
  input  logic [7:0] debug_port1,
  input  logic [7:0] debug_port2,
  input  logic [7:0] debug_port3,
  input  logic [7:0] debug_port4,
  input  logic [7:0] debug_port5,
  input  logic [7:0] debug_port6,
  input  logic [7:0] debug_port7,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
`else
  localparam logic [3:0] LAST_BYTE = 4'd7;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q;
  logic [CW-1:0]   baud_q;
  logic [CW-1:0]   baud_d;
  logic [3:0]      byte_q;
  logic [2:0]      bit_q;
  logic [2:0]      bit_d;
  logic [6:0][7:0] snap_q;
  logic            tx_q;
  logic            done_q;
  logic [7:0]      cur_byte;

  assign baud_d = baud_q + CW'(1);
  assign bit_d  = bit_q + 3'd1;

`ifdef DEBUG_TX_CHECKSUM_EN
  logic [7:0] chk;

  always_comb begin
    chk = 8'h00;
    for (int i = 0; i < 7; i++) chk = chk ^ snap_q[i];
  end
`endif

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_q)
      4'd1: cur_byte = snap_q[0];
      4'd2: cur_byte = snap_q[1];
      4'd3: cur_byte = snap_q[2];
      4'd4: cur_byte = snap_q[3];
      4'd5: cur_byte = snap_q[4];
      4'd6: cur_byte = snap_q[5];
      4'd7: cur_byte = snap_q[6];
`ifdef DEBUG_TX_CHECKSUM_EN
      4'd8: cur_byte = chk;
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // tx is loaded one state ahead so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      byte_q  <= 4'd0;
      bit_q   <= 3'd0;
      snap_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (trigger) begin
            snap_q  <= {debug_port7, debug_port6, debug_port5, debug_port4,
                        debug_port3, debug_port2, debug_port1};
            byte_q  <= 4'd0;
            baud_q  <= '0;
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= '0;
            bit_q   <= 3'd0;
            state_q <= DATA;
            tx_q    <= cur_byte[0];
          end else begin
            baud_q <= baud_d;
          end
        end
        DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_d;
              tx_q  <= cur_byte[bit_d];
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= '0;
            if (byte_q == LAST_BYTE) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              byte_q  <= byte_q + 4'd1;
              state_q <= START;
              tx_q    <= 1'b0;
            end
          end else begin
            baud_q <= baud_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Testbench for debug_uart_tx: a line decoder feeds a byte scoreboard; frame timing and control are checked alongside.
module tb_debug_uart_tx;

  localparam int N = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int NUM_BYTES = 9;
`else
  localparam int NUM_BYTES = 8;
`endif
  localparam int FRAME_CYC = NUM_BYTES * 10 * N;

  logic       clk;
  logic       nreset;
  logic       trigger;
  logic [7:0] portVal [0:6];
  logic       tx;
  logic       busy;
  logic       frame_done;

  int errorCount;
  int checkCount;
  int cycleCount;
  int trigEdge;
  int doneCount;
  int busyFalls;
  logic prevBusy;
  logic [7:0] expQ [$];

  bit         rxActive;
  int         rxCnt;
  logic [7:0] rxShift;

  debug_uart_tx #(.CLKS_PER_BIT(N), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .nreset(nreset),
    .trigger(trigger),
    .debug_port1(portVal[0]),
    .debug_port2(portVal[1]),
    .debug_port3(portVal[2]),
    .debug_port4(portVal[3]),
    .debug_port5(portVal[4]),
    .debug_port6(portVal[5]),
    .debug_port7(portVal[6]),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount = cycleCount + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual !== expected) begin
      errorCount = errorCount + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Line decoder: samples mid-bit on falling edges and compares each byte against the scoreboard.
  always @(negedge clk) begin
    if (!nreset) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (tx == 1'b0) begin
        rxActive = 1'b1;
        rxCnt    = 0;
      end
    end else begin
      rxCnt = rxCnt + 1;
      if (rxCnt == N / 2) begin
        checkOutput("rxStartBit", {31'd0, tx}, 32'd0);
      end else if (rxCnt == 9 * N + N / 2) begin
        checkOutput("rxStopBit", {31'd0, tx}, 32'd1);
        if (expQ.size() == 0) begin
          checkOutput("rxUnexpectedByte", {24'd0, rxShift}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("rxByte", {24'd0, rxShift}, {24'd0, expQ.pop_front()});
        end
        rxActive = 1'b0;
      end else if ((rxCnt % N) == N / 2) begin
        rxShift[rxCnt / N - 1] = tx;
      end
    end
  end

  always @(negedge clk) begin
    if (frame_done) doneCount = doneCount + 1;
    if (prevBusy && !busy) busyFalls = busyFalls + 1;
    prevBusy = busy;
  end

  // Drives the ports and queues the frame the DUT should send for them.
  task automatic applyStimulus(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                               input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
                               input logic [7:0] p6);
    logic [7:0] chk;
    portVal[0] = p0; portVal[1] = p1; portVal[2] = p2; portVal[3] = p3;
    portVal[4] = p4; portVal[5] = p5; portVal[6] = p6;
    chk = p0 ^ p1 ^ p2 ^ p3 ^ p4 ^ p5 ^ p6;
    expQ.push_back(8'hA5);
    for (int i = 0; i < 7; i++) expQ.push_back(portVal[i]);
    if (NUM_BYTES == 9) expQ.push_back(chk);
  endtask

  task automatic pulseTrigger();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigEdge = cycleCount;
    trigger = 1'b0;
  endtask

  task automatic waitFrameDone(input string tag, input int limit);
    bit found;
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) checkOutput({tag, "Timeout"}, {31'd0, frame_done}, 32'd1);
    else checkOutput({tag, "Latency"}, cycleCount - trigEdge, FRAME_CYC);
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    int doneBase;
    int fallBase;
    int badIdle;
    errorCount = 0;
    checkCount = 0;
    cycleCount = 0;
    doneCount  = 0;
    busyFalls  = 0;
    prevBusy   = 1'b0;
    rxActive   = 1'b0;
    rxCnt      = 0;
    rxShift    = 8'h00;
    trigger    = 1'b0;
    for (int i = 0; i < 7; i++) portVal[i] = 8'h00;

    nreset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("resetTx", {31'd0, tx}, 32'd1);
      checkOutput("resetBusy", {31'd0, busy}, 32'd0);
      checkOutput("resetDone", {31'd0, frame_done}, 32'd0);
    end
    nreset = 1'b1;
    waitCycles(5);
    checkOutput("idleTx", {31'd0, tx}, 32'd1);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);

    $display("[TB] single frame");
    applyStimulus(8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40);
    pulseTrigger();
    checkOutput("startTx", {31'd0, tx}, 32'd0);
    checkOutput("startBusy", {31'd0, busy}, 32'd1);
    waitFrameDone("single", FRAME_CYC + 20);
    checkOutput("endTx", {31'd0, tx}, 32'd1);
    checkOutput("endBusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("donePulseWidth", {31'd0, frame_done}, 32'd0);
    waitCycles(4);
    checkOutput("singleQueueEmpty", expQ.size(), 0);

    $display("[TB] snapshot hold");
    applyStimulus(8'h3C, 8'h81, 8'h7E, 8'h00, 8'hC3, 8'h5A, 8'h96);
    pulseTrigger();
    waitCycles(2 * 10 * N + 5);
    for (int i = 0; i < 7; i++) portVal[i] = 8'hFF;
    waitFrameDone("snapshot", FRAME_CYC + 20);
    waitCycles(4);
    checkOutput("snapshotQueueEmpty", expQ.size(), 0);

    $display("[TB] trigger while busy");
    @(posedge clk);
    doneBase = doneCount;
    fallBase = busyFalls;
    applyStimulus(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56);
    pulseTrigger();
    waitCycles(5 * 10 * N);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    waitFrameDone("busyTrig", FRAME_CYC + 20);
    waitCycles(3 * 10 * N);
    @(posedge clk);
    checkOutput("busyTrigDoneCount", doneCount - doneBase, 1);
    checkOutput("busyTrigBusyFalls", busyFalls - fallBase, 1);
    checkOutput("busyTrigQueueEmpty", expQ.size(), 0);

    $display("[TB] back to back");
    applyStimulus(8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h99, 8'h66, 8'h11);
    applyStimulus(8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h99, 8'h66, 8'h11);
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigEdge = cycleCount;
    waitFrameDone("b2bFirst", FRAME_CYC + 20);
    checkOutput("b2bIdleTx", {31'd0, tx}, 32'd1);
    checkOutput("b2bIdleBusy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    trigEdge = cycleCount;
    checkOutput("b2bRestartTx", {31'd0, tx}, 32'd0);
    checkOutput("b2bRestartBusy", {31'd0, busy}, 32'd1);
    trigger = 1'b0;
    waitFrameDone("b2bSecond", FRAME_CYC + 20);
    waitCycles(4);
    checkOutput("b2bQueueEmpty", expQ.size(), 0);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED);
    pulseTrigger();
    waitCycles(4 * 10 * N + 4 * N + 1);
    @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    checkOutput("midResetTx", {31'd0, tx}, 32'd1);
    checkOutput("midResetBusy", {31'd0, busy}, 32'd0);
    expQ.delete();
    waitCycles(2);
    nreset = 1'b1;
    @(posedge clk);
    doneBase = doneCount;
    badIdle = 0;
    for (int i = 0; i < 12 * N; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) badIdle = badIdle + 1;
    end
    checkOutput("postResetIdle", badIdle, 0);
    @(posedge clk);
    checkOutput("postResetNoDone", doneCount - doneBase, 0);
    applyStimulus(8'h13, 8'h57, 8'h9B, 8'hDF, 8'h02, 8'h46, 8'h8A);
    pulseTrigger();
    waitFrameDone("postReset", FRAME_CYC + 20);
    waitCycles(4);
    checkOutput("postResetQueueEmpty", expQ.size(), 0);

    $display("[TB] Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
